rf_wb_queue: RTL and testbench
==============================

// Module: rf_wb_queue
// PURPOSE
//  Write-initiator for the 32x32 register file: buffers writeback requests from the datapath
//  in a small in-order queue and retires them one per cycle onto the RF write port
//  (RdAddr/RdData/RegWrite). Provides youngest-match bypass of pending data for the two
//  RF read addresses, so reads never return stale values while writes are queued.
// PARAMETERS
//  DEPTH   4   queue entries (power of 2, >=2)
//  DATA_W  32  register data width
//  ADDR_W  5   register address width (32 registers)
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  rst       in   1       synchronous reset, active-high
//  in_valid  in   1       writeback request valid
//  in_ready  out  1       queue can accept; = (count < DEPTH)
//  in_addr   in   ADDR_W  destination register
//  in_data   in   DATA_W  write data
//  drain_en  in   1       RF write slot available this cycle
//  RdAddr    out  ADDR_W  RF write address (head entry)
//  RdData    out  DATA_W  RF write data (head entry)
//  RegWrite  out  1       RF write strobe
//  rs_addr   in   ADDR_W  lookup address A (same value driven to RF RsAddr)
//  rt_addr   in   ADDR_W  lookup address B (same value driven to RF RtAddr)
//  rs_hit    out  1       pending write to rs_addr exists
//  rs_fwd    out  DATA_W  youngest pending data for rs_addr (0 when !rs_hit)
//  rt_hit    out  1       as rs_hit for rt_addr
//  rt_fwd    out  DATA_W  as rs_fwd for rt_addr
//  count     out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Storage: circular buffer, wr_ptr/rd_ptr log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
//  - Push: in_valid & in_ready & (in_addr != 0) -> entry {in_addr,in_data} at wr_ptr, wr_ptr++.
//  - Writes to register 0 are accepted (handshake completes) and discarded: no entry, no count change.
//  - Pop: pop = drain_en & (count != 0). Combinational: RegWrite = pop;
//    RdAddr/RdData = head entry when count!=0, else 0. rd_ptr++ on the edge ending a pop cycle.
//  - Latency: request accepted in cycle N reaches RegWrite no earlier than cycle N+1.
//  - Push and pop same cycle: count unchanged, both pointers advance. in_ready is 0 when full even
//    if a pop occurs that cycle (no pass-through).
//  - Order: entries retire strictly in acceptance order; repeated writes to one register all retire.
//  - Bypass (combinational): search all occupied entries including the head being popped;
//    youngest (closest to wr_ptr) match wins. Address 0 never hits. Incoming in_* not searched.
//  - Reset (rst=1 at edge): count=0, wr_ptr=rd_ptr=0 -> RegWrite=0, RdAddr=0, RdData=0,
//    rs_hit=rt_hit=0, rs_fwd=rt_fwd=0, in_ready=1. Pending entries discarded, including mid-drain.
//    Entry storage need not be cleared. in_valid ignored while rst=1.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> count=0, RegWrite=0, RdAddr=0, RdData=0, in_ready=1.
//  2 Push {3,0xDEADBEEF}, drain_en=0 -> count=1, rs_addr=3 gives rs_hit=1, rs_fwd=0xDEADBEEF;
//    drain_en=1 -> RegWrite=1, RdAddr=3, RdData=0xDEADBEEF for 1 cycle, then count=0, rs_hit=0.
//  3 Fill: push 4 entries to reg 7 (data 1,2,3,4), drain_en=0 -> in_ready=0, count=4, rt_addr=7
//    gives rt_fwd=4; 5th request held; drain -> RdData 1,2,3,4 on 4 consecutive cycles.
//  4 Wrap: 10 back-to-back pushes {i,i*0x11} with drain_en=1 -> RF receives all 10 in order,
//    count never exceeds 1, pointers wrap cleanly.
//  5 Reg 0: push {0,0x55} -> in_ready=1 handshake, count stays 0, RegWrite never asserted, rs_addr=0 no hit.
//  6 Reset mid-drain: 3 entries queued, drain_en=1, assert rst after first retire -> next cycle
//    count=0, RegWrite=0, no further writes to RF.

Source files
------------

// File: rtl/rf_wb_queue_if.sv
// Writeback request channel into rf_wb_queue.
// Ports: in_valid/in_addr/in_data from master, in_ready from slave.
interface rf_wb_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/rf_wb_queue.sv
// In-order writeback queue feeding the RF write port, with
// youngest-match bypass for the rs/rt read addresses.
// Ports: clk, rst (sync, high); wb push channel (slave);
// drain_en -> RdAddr/RdData/RegWrite; rs/rt lookup -> hit/fwd;
// count = occupied entries.
module rf_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_queue_if.slave      wb,
  input  logic              drain_en,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_hit,
  output logic [DATA_W-1:0] rs_fwd,
  output logic              rt_hit,
  output logic [DATA_W-1:0] rt_fwd,
  output logic [CW-1:0]     count
);

  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic              notEmpty;
  logic              push;
  logic              pop;

  assign notEmpty    = (count != '0);
  // No pass-through: a pop in the same cycle does not open a full queue.
  assign wb.in_ready = (count < CW'(DEPTH));
  // Register 0 requests complete the handshake but are dropped.
  assign push = wb.in_valid & wb.in_ready &
                (wb.in_addr != '0);
  assign pop  = drain_en & notEmpty;

  assign RegWrite = pop;
  assign RdAddr   = notEmpty ? addrQ[rdPtr] : '0;
  assign RdData   = notEmpty ? dataQ[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addrQ[wrPtr] <= wb.in_addr;
      dataQ[wrPtr] <= wb.in_data;
    end
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    rs_hit = 1'b0;
    rs_fwd = '0;
    rt_hit = 1'b0;
    rt_fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if (CW'(k) < count) begin
        if (rs_addr != '0 &&
            addrQ[idx] == rs_addr) begin
          rs_hit = 1'b1;
          rs_fwd = dataQ[idx];
        end
        if (rt_addr != '0 &&
            addrQ[idx] == rt_addr) begin
          rt_hit = 1'b1;
          rt_fwd = dataQ[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_rf_wb_queue;

  logic        clk;
  logic        rst;
  logic        drain_en;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic        RegWrite;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_hit;
  logic [31:0] rs_fwd;
  logic        rt_hit;
  logic [31:0] rt_fwd;
  logic [2:0]  count;

  int nCmp = 0;
  int nBad = 0;

  rf_wb_queue_if #(.ADDR_W(5), .DATA_W(32)) wb ();

  rf_wb_queue #(
    .DEPTH(4), .DATA_W(32), .ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb.slave),
    .drain_en(drain_en),
    .RdAddr(RdAddr),
    .RdData(RdData),
    .RegWrite(RegWrite),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_hit(rs_hit),
    .rs_fwd(rs_fwd),
    .rt_hit(rt_hit),
    .rt_fwd(rt_fwd),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drv(input logic v,
                     input logic [4:0] a,
                     input logic [31:0] d);
    wb.in_valid = v;
    wb.in_addr  = a;
    wb.in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    drain_en = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    drv(1'b1, 5'd5, 32'h1234);

    // Reset held 2 cycles with in_valid high
    repeat (2) @(posedge clk);
    nxt(); #1;
    chk("rst_count", count, 0);
    chk("rst_regwr", RegWrite, 0);
    chk("rst_rdaddr", RdAddr, 0);
    chk("rst_rddata", RdData, 0);
    chk("rst_ready", wb.in_ready, 1);
    chk("rst_rshit", rs_hit, 0);

    // Single push then drain
    rst = 1'b0;
    drv(1'b1, 5'd3, 32'hDEADBEEF);
    nxt();
    drv(1'b0, 5'd0, 32'h0);
    rs_addr = 5'd3;
    #1;
    chk("p1_count", count, 1);
    chk("p1_nowr", RegWrite, 0);
    chk("p1_rshit", rs_hit, 1);
    chk("p1_rsfwd", rs_fwd, 32'hDEADBEEF);
    drain_en = 1'b1;
    #1;
    chk("p1_regwr", RegWrite, 1);
    chk("p1_rdaddr", RdAddr, 3);
    chk("p1_rddata", RdData, 32'hDEADBEEF);
    chk("p1_headhit", rs_hit, 1);
    nxt();
    drain_en = 1'b0;
    #1;
    chk("p1_empty", count, 0);
    chk("p1_rsmiss", rs_hit, 0);
    chk("p1_rsfwd0", rs_fwd, 0);
    chk("p1_wrdone", RegWrite, 0);

    // Fill to full with reg 7
    rt_addr = 5'd7;
    rs_addr = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 5'd7, 32'(i));
      nxt();
    end
    drv(1'b1, 5'd7, 32'd5);
    #1;
    chk("f_full_rdy", wb.in_ready, 0);
    chk("f_count", count, 4);
    chk("f_rthit", rt_hit, 1);
    chk("f_rtfwd", rt_fwd, 4);
    chk("f_rsmiss", rs_hit, 0);
    nxt(); #1;
    chk("f_held", count, 4);
    drain_en = 1'b1;
    #1;
    chk("f_nopass", wb.in_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("f_dr_wr", RegWrite, 1);
      chk("f_dr_data", RdData, 32'(k));
      chk("f_dr_addr", RdAddr, 7);
      nxt();
      drv(1'b0, 5'd0, 32'h0);
      #1;
      chk("f_dr_cnt", count, 3'(4 - k));
    end
    chk("f_dr_end", RegWrite, 0);

    // Back-to-back pushes while draining
    for (int i = 1; i <= 10; i++) begin
      drv(1'b1, 5'(i), 32'(i * 32'h11));
      #1;
      if (i > 1) begin
        chk("w_wr", RegWrite, 1);
        chk("w_addr", RdAddr, 5'(i - 1));
        chk("w_data", RdData,
            32'((i - 1) * 32'h11));
        chk("w_cnt", count, 1);
      end else begin
        chk("w_cnt0", count, 0);
      end
      nxt();
    end
    drv(1'b0, 5'd0, 32'h0);
    #1;
    chk("w_last_addr", RdAddr, 10);
    chk("w_last_data", RdData, 32'hAA);
    chk("w_last_wr", RegWrite, 1);
    nxt(); #1;
    chk("w_empty", count, 0);
    chk("w_nowr", RegWrite, 0);

    // Register 0 write is discarded
    drv(1'b1, 5'd0, 32'h55);
    rs_addr = 5'd0;
    #1;
    chk("z_ready", wb.in_ready, 1);
    nxt();
    drv(1'b0, 5'd0, 32'h0);
    #1;
    chk("z_count", count, 0);
    chk("z_nowr", RegWrite, 0);
    chk("z_nohit", rs_hit, 0);

    // Reset mid-drain
    drain_en = 1'b0;
    rs_addr = 5'd11;
    drv(1'b1, 5'd9, 32'hA);
    nxt();
    drv(1'b1, 5'd10, 32'hB);
    nxt();
    drv(1'b1, 5'd11, 32'hC);
    nxt();
    drv(1'b0, 5'd0, 32'h0);
    drain_en = 1'b1;
    #1;
    chk("r_count", count, 3);
    chk("r_rshit", rs_hit, 1);
    chk("r_first", RdAddr, 9);
    chk("r_firstwr", RegWrite, 1);
    nxt();
    rst = 1'b1;
    #1;
    chk("r_second", RdAddr, 10);
    nxt();
    rst = 1'b0;
    #1;
    chk("r_cnt0", count, 0);
    chk("r_nowr", RegWrite, 0);
    chk("r_addr0", RdAddr, 0);
    chk("r_data0", RdData, 0);
    chk("r_nohit", rs_hit, 0);
    chk("r_ready", wb.in_ready, 1);
    nxt(); #1;
    chk("r_still0", RegWrite, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
